// File: rtl/acc_stream_if.sv
// acc_stream handshake bundle: operand stream in, packet result out.
// master drives beats and out_ready; slave is the accumulator.
interface acc_stream_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ACC_WIDTH  = 40,
   parameter int CNT_WIDTH  = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_last;
   logic                  out_valid;
   logic                  out_ready;
   logic [ACC_WIDTH-1:0]  out_sum;
   logic [CNT_WIDTH-1:0]  out_count;
   logic                  out_ovf;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_count, out_ovf
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_count, out_ovf
   );
endinterface

// File: rtl/acc_stream.sv
// Streaming packet accumulator fed through a carry-select adder.
// One add per cycle; packet total, beat count and carry flag on output.
module csa #(
   parameter int DATA_WIDTH = 32,
   parameter int STAGE_SIZE = 4
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic                  ci,
   output logic [DATA_WIDTH-1:0] sum,
   output logic                  co
);
   localparam int NS = DATA_WIDTH / STAGE_SIZE;

   logic [STAGE_SIZE:0] s0;
   logic [STAGE_SIZE:0] s1;
   logic                c;

   // Each stage precomputes both carry-in cases and selects on the ripple
   always_comb begin
      sum = '0;
      s0  = '0;
      s1  = '0;
      c   = ci;
      for (int i = 0; i < NS; i++) begin
         s0 = {1'b0, a[i*STAGE_SIZE +: STAGE_SIZE]}
            + {1'b0, b[i*STAGE_SIZE +: STAGE_SIZE]};
         s1 = s0 + (STAGE_SIZE+1)'(1);
         sum[i*STAGE_SIZE +: STAGE_SIZE] =
            c ? s1[STAGE_SIZE-1:0] : s0[STAGE_SIZE-1:0];
         c = c ? s1[STAGE_SIZE] : s0[STAGE_SIZE];
      end
      co = c;
   end
endmodule

module acc_stream #(
   parameter int DATA_WIDTH = 32,
   parameter int ACC_WIDTH  = 40,
   parameter int STAGE_SIZE = 4,
   parameter int CNT_WIDTH  = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   acc_stream_if.slave  s
);
   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   state_t               state_q, state_d;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 ovf_q, ovf_d;
   logic                 out_valid_q, out_valid_d;
   logic [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
   logic [CNT_WIDTH-1:0] out_count_q, out_count_d;
   logic                 out_ovf_q, out_ovf_d;

   logic                 fresh;
   logic                 accept;
   logic [ACC_WIDTH-1:0] a_op;
   logic [ACC_WIDTH-1:0] b_op;
   logic [ACC_WIDTH-1:0] sum;
   logic                 co;
   logic [CNT_WIDTH-1:0] base_cnt;
   logic [CNT_WIDTH-1:0] cnt_inc;
   logic                 base_ovf;

   // A beat outside ACC always opens a new packet from zero
   assign fresh    = (state_q != ACC);
   assign s.in_ready = ~clr & ((state_q != DONE) | s.out_ready);
   assign accept   = s.in_valid & s.in_ready;
   assign a_op     = fresh ? '0 : acc_q;
   assign b_op     = ACC_WIDTH'(s.in_data);
   assign base_cnt = fresh ? '0 : cnt_q;
   assign base_ovf = fresh ? 1'b0 : ovf_q;
   assign cnt_inc  = (base_cnt == CNT_MAX) ? base_cnt
                   : base_cnt + CNT_WIDTH'(1);

   csa #(
      .DATA_WIDTH (ACC_WIDTH),
      .STAGE_SIZE (STAGE_SIZE)
   ) u_csa (
      .a   (a_op),
      .b   (b_op),
      .ci  (1'b0),
      .sum (sum),
      .co  (co)
   );

   // Next state: clear wins, then drain, then the accepted beat
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_count_d = out_count_q;
      out_ovf_d   = out_ovf_q;
      if (clr) begin
         state_d     = IDLE;
         acc_d       = '0;
         cnt_d       = '0;
         ovf_d       = 1'b0;
         out_valid_d = 1'b0;
         out_sum_d   = '0;
         out_count_d = '0;
         out_ovf_d   = 1'b0;
      end else begin
         if (state_q == DONE && s.out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
         if (accept) begin
            if (s.in_last) begin
               out_sum_d   = sum;
               out_count_d = cnt_inc;
               out_ovf_d   = base_ovf | co;
               out_valid_d = 1'b1;
               acc_d       = '0;
               cnt_d       = '0;
               ovf_d       = 1'b0;
               state_d     = DONE;
            end else begin
               acc_d   = sum;
               cnt_d   = cnt_inc;
               ovf_d   = base_ovf | co;
               state_d = ACC;
            end
         end
      end
   end

   // State and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_count_q <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_count_q <= out_count_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   assign s.out_valid = out_valid_q;
   assign s.out_sum   = out_sum_q;
   assign s.out_count = out_count_q;
   assign s.out_ovf   = out_ovf_q;
endmodule

// File: doc/acc_stream.md
Name: acc_stream

Overview:
- Streaming unsigned accumulator sitting directly downstream of the team's carry-select adder (csa).
- Accepts a packet of operands over a valid/ready input, sums them into an ACC_WIDTH register, and presents the packet total, beat count and overflow flag on a valid/ready output.
- The adder path is one csa instance (DATA_WIDTH=ACC_WIDTH, STAGE_SIZE=STAGE_SIZE, ci=0). Its sum and co are registered here, giving one add per cycle.

Parameters:
- DATA_WIDTH, 32: operand width.
- ACC_WIDTH, 40: accumulator/result width. Must be >= DATA_WIDTH and divisible by STAGE_SIZE.
- STAGE_SIZE, 4: csa stage size passed to the adder instance.
- CNT_WIDTH, 8: beat-counter width.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- clr, input, 1: synchronous clear; highest priority after reset.
- in_valid, input, 1: operand beat valid.
- in_ready, output, 1: block can accept a beat this cycle.
- in_data, input, DATA_WIDTH: unsigned operand.
- in_last, input, 1: marks the final beat of a packet.
- out_valid, output, 1: result held and valid.
- out_ready, input, 1: downstream accepts the result.
- out_sum, output, ACC_WIDTH: packet total, modulo 2^ACC_WIDTH.
- out_count, output, CNT_WIDTH: beats in the packet, saturating.
- out_ovf, output, 1: sticky flag, set if any add in the packet produced csa co=1.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, acc=0, cnt=0, ovf=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0.
- Reset mid-packet discards everything.
- States:
  - IDLE: acc=0, no beats yet.
  - ACC: at least one beat taken, in_last not yet seen.
  - DONE: result held.
- in_ready = (state!=DONE) | out_ready. It is combinational from state and out_ready.
- in_valid must not depend on in_ready.
- Accept = in_valid & in_ready.
- Adder inputs:
  - a = acc, or 0 when starting a fresh packet (state IDLE, or DONE being drained).
  - b = in_data zero-extended to ACC_WIDTH.
- On accept with in_last=0:
  - acc <= sum; cnt <= base_cnt+1 (saturate at 2^CNT_WIDTH-1); ovf <= base_ovf | co.
  - next state = ACC.
- On accept with in_last=1:
  - out_sum <= sum; out_count <= base_cnt+1 (saturating); out_ovf <= base_ovf | co.
  - out_valid <= 1; acc, cnt, ovf <= 0; next state = DONE.
- Base values: base_cnt/base_ovf are 0 for a fresh packet, otherwise the current cnt/ovf.
- Latency: the result is visible the cycle after the in_last beat is accepted.
- DONE:
  - out_sum, out_count and out_ovf stay stable while out_valid=1 and out_ready=0.
  - out_ready=1 with no accept: out_valid <= 0, state -> IDLE.
  - out_ready=1 with an accept in the same cycle: the output drains and the beat starts a new packet (zero bubble).
  - If that beat also carries in_last, out_valid stays 1 with the new result (one-beat packet).
- Single-beat packet from IDLE (in_last on the first beat) -> DONE directly with count=1.
- Overflow: acc wraps modulo 2^ACC_WIDTH; out_ovf stays 1 for the rest of that packet.
- Counter saturates and never wraps.
- clr=1 (sync): same effect as reset on the next edge. Drops any partial packet and any held result. in_ready is forced to 0 in that cycle and no beat is accepted.
- Outputs are registered. Only in_ready has a combinational path, from out_ready.

Test Plan:
- Reset, then packet 5, 7, 9 (last on 9), out_ready=1 -> one cycle after the last accept: out_valid=1, out_sum=21, out_count=3, out_ovf=0; then out_valid=0.
- ACC_WIDTH=32 override: beats 0xFFFF_FFFF, 0x2 (last) -> out_sum=0x1, out_ovf=1. The next packet 3 (last) -> out_sum=3, out_ovf=0.
- Backpressure: packet 1, 2 (last), out_ready=0 for 4 cycles -> in_ready=0 and outputs stable at sum=3, count=2. Raise out_ready with in_valid, in_data=10, in_last=1 -> next cycle out_sum=10, out_count=1, out_valid still 1.
- Counter saturation, CNT_WIDTH=2: five beats of 1 -> out_count=3, out_sum=5.
- clr mid-packet: beats 4, 4, then clr, then 6 (last) -> out_sum=6, out_count=1. clr while DONE -> out_valid=0 the next cycle.
- Async reset: assert rst_n=0 mid-cycle during ACC -> all outputs 0 immediately. Release, then a single beat 8 (last) -> out_sum=8.
